// File: rtl/d5m_frame_gate.sv
// d5m_frame_gate
// Watches the raw D5M stream (FVAL/LVAL/12-bit data). After a software arm it
// forwards exactly one complete frame, cropped to a programmable window, as a
// registered pixel/valid stream with window-relative coordinates. It also
// reports busy, a one-cycle done pulse, a sticky short-frame error and a count
// of the pixels it kept.
// Build option: define DECIMATE_2X_EN to keep only the even window-relative
// columns and lines, with halved output coordinates.
module d5m_frame_gate #(
    parameter int unsigned X_START = 0,
    parameter int unsigned Y_START = 0,
    parameter int unsigned WIN_W   = 640,
    parameter int unsigned WIN_H   = 480,
    parameter int unsigned COORD_W = 12,
    parameter int unsigned CNT_W   = 20
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               iFVAL,
    input  logic               iLVAL,
    input  logic [11:0]        iDATA,
    input  logic               iARM,
    output logic [11:0]        oDATA,
    output logic               oDATA_VAL,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY,
    output logic               oBUSY,
    output logic               oFRAME_DONE,
    output logic               oERR,
    output logic [CNT_W-1:0]   oPIX_COUNT
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        CAPTURE,
        DONE
    } state_t;

`ifdef DECIMATE_2X_EN
    localparam longint unsigned EXP_FULL = 64'(WIN_W / 2) * 64'(WIN_H / 2);
`else
    localparam longint unsigned EXP_FULL = 64'(WIN_W) * 64'(WIN_H);
`endif
    localparam logic [CNT_W-1:0] EXPECTED = CNT_W'(EXP_FULL);

    // Bounds are one bit wider than the counters so that a window ending
    // exactly at the top of the coordinate range is still representable.
    localparam logic [COORD_W:0]   X_LO  = (COORD_W+1)'(X_START);
    localparam logic [COORD_W:0]   X_HI  = (COORD_W+1)'(X_START + WIN_W);
    localparam logic [COORD_W:0]   Y_LO  = (COORD_W+1)'(Y_START);
    localparam logic [COORD_W:0]   Y_HI  = (COORD_W+1)'(Y_START + WIN_H);
    localparam logic [COORD_W-1:0] X_OFF = COORD_W'(X_START);
    localparam logic [COORD_W-1:0] Y_OFF = COORD_W'(Y_START);

    // Elaboration-time checks on the window geometry.
    generate
        if (EXP_FULL == 0 || EXP_FULL > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_expected
            $error("d5m_frame_gate: kept-pixel total must be nonzero and fit in CNT_W bits");
        end
        if (64'(X_START) + 64'(WIN_W) > (64'd1 << COORD_W) ||
            64'(Y_START) + 64'(WIN_H) > (64'd1 << COORD_W)) begin : g_bad_window
            $error("d5m_frame_gate: window exceeds the COORD_W coordinate range");
        end
`ifdef DECIMATE_2X_EN
        if ((WIN_W % 2) != 0 || (WIN_H % 2) != 0) begin : g_bad_decim
            $error("d5m_frame_gate: WIN_W and WIN_H must be even when decimating");
        end
`endif
    endgenerate

    state_t             state;
    state_t             state_next;
    logic               fval_d;
    logic               lval_d;
    logic               sof;
    logic               eol;
    logic               eof;
    logic               pix;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] line;
    logic [COORD_W-1:0] col_cur;
    logic [COORD_W-1:0] line_cur;
    logic [COORD_W-1:0] col_inc;
    logic [COORD_W-1:0] line_inc;
    logic [COORD_W-1:0] rel_x;
    logic [COORD_W-1:0] rel_y;
    logic               in_win;
    logic               capturing;
    logic               arm_accept;
    logic               keep;
    logic               count_hit;
    logic               finish_err;
    logic [CNT_W-1:0]   pix_count;
    logic [CNT_W-1:0]   pix_inc;

    assign sof = iFVAL & ~fval_d;
    assign eol = ~iLVAL & lval_d & iFVAL;
    assign eof = ~iFVAL & fval_d;
    assign pix = iFVAL & iLVAL;

    // The registered counters still hold the previous frame's values during
    // the SOF cycle, so that cycle's pixel is forced to column 0, line 0.
    assign col_cur  = sof ? '0 : col;
    assign line_cur = sof ? '0 : line;
    assign col_inc  = (&col)  ? col  : col  + COORD_W'(1);
    assign line_inc = (&line) ? line : line + COORD_W'(1);
    assign rel_x    = col_cur  - X_OFF;
    assign rel_y    = line_cur - Y_OFF;
    assign pix_inc  = pix_count + CNT_W'(1);

    // Decide whether the current sensor pixel lies inside the capture window.
    always_comb begin
        in_win = ({1'b0, col_cur}  >= X_LO) && ({1'b0, col_cur}  < X_HI) &&
                 ({1'b0, line_cur} >= Y_LO) && ({1'b0, line_cur} < Y_HI);
`ifdef DECIMATE_2X_EN
        in_win = in_win & ~rel_x[0] & ~rel_y[0];
`endif
    end

    // Compute the next state and the per-cycle capture strobes.
    always_comb begin
        state_next = state;
        capturing  = 1'b0;
        arm_accept = 1'b0;
        finish_err = 1'b0;
        case (state)
            IDLE: begin
                if (iARM) begin
                    arm_accept = 1'b1;
                    state_next = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (sof) begin
                    capturing  = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                capturing = 1'b1;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        keep      = capturing & pix & in_win;
        count_hit = keep && (pix_inc == EXPECTED);
        // Reaching the full count takes priority over a same-cycle frame end.
        if (capturing) begin
            if (count_hit) begin
                state_next = DONE;
            end else if (eof) begin
                finish_err = 1'b1;
                state_next = DONE;
            end
        end
    end

    // Register the capture state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Delay FVAL/LVAL for edge detection, and track the sensor column and line.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // Both delays start high: a frame already running at reset is not a SOF.
            fval_d <= 1'b1;
            lval_d <= 1'b1;
            col    <= '0;
            line   <= '0;
        end else begin
            fval_d <= iFVAL;
            lval_d <= iLVAL;
            if (sof) begin
                col  <= pix ? COORD_W'(1) : '0;
                line <= '0;
            end else if (eol) begin
                col  <= '0;
                line <= line_inc;
            end else if (pix) begin
                col  <= col_inc;
            end
        end
    end

    // Forward kept pixels and maintain the busy, done, error and count outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            oDATA       <= '0;
            oDATA_VAL   <= 1'b0;
            oX          <= '0;
            oY          <= '0;
            oBUSY       <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oERR        <= 1'b0;
            pix_count   <= '0;
        end else begin
            oDATA_VAL   <= keep;
            oFRAME_DONE <= (state_next == DONE);
            if (keep) begin
                oDATA     <= iDATA;
                pix_count <= pix_inc;
`ifdef DECIMATE_2X_EN
                oX <= {1'b0, rel_x[COORD_W-1:1]};
                oY <= {1'b0, rel_y[COORD_W-1:1]};
`else
                oX <= rel_x;
                oY <= rel_y;
`endif
            end
            if (arm_accept) begin
                oBUSY     <= 1'b1;
                oERR      <= 1'b0;
                pix_count <= '0;
            end
            if (finish_err) begin
                oERR <= 1'b1;
            end
            if (state == DONE) begin
                oBUSY <= 1'b0;
            end
        end
    end

    assign oPIX_COUNT = pix_count;

endmodule

// File: tb/tb_d5m_frame_gate.sv
// tb_d5m_frame_gate
// Directed bench: 8-column sensor frames whose pixel value encodes the sensor
// position as {line[5:0], col[5:0]}. Window geometry follows DECIMATE_2X_EN.
module tb_d5m_frame_gate;

`ifdef DECIMATE_2X_EN
    localparam int XS = 0, YS = 0, WW = 4, WH = 4, STEP = 2;
    localparam int SHORT_CNT = 2;
`else
    localparam int XS = 2, YS = 1, WW = 4, WH = 3, STEP = 1;
    localparam int SHORT_CNT = 4;
`endif
    localparam int FULL_CNT = (WW / STEP) * (WH / STEP);
    localparam int CW = 12;
    localparam int NW = 20;

    logic          CLK;
    logic          RST;
    logic          iFVAL;
    logic          iLVAL;
    logic [11:0]   iDATA;
    logic          iARM;
    logic [11:0]   oDATA;
    logic          oDATA_VAL;
    logic [CW-1:0] oX;
    logic [CW-1:0] oY;
    logic          oBUSY;
    logic          oFRAME_DONE;
    logic          oERR;
    logic [NW-1:0] oPIX_COUNT;

    int checks   = 0;
    int failures = 0;

    logic [11:0]   q_data[$];
    logic [CW-1:0] q_x[$];
    logic [CW-1:0] q_y[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int eof_cyc  = 0;
    int cyc      = 0;
    logic fval_prev = 1'b0;

    d5m_frame_gate #(
        .X_START(XS),
        .Y_START(YS),
        .WIN_W  (WW),
        .WIN_H  (WH),
        .COORD_W(CW),
        .CNT_W  (NW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .iFVAL      (iFVAL),
        .iLVAL      (iLVAL),
        .iDATA      (iDATA),
        .iARM       (iARM),
        .oDATA      (oDATA),
        .oDATA_VAL  (oDATA_VAL),
        .oX         (oX),
        .oY         (oY),
        .oBUSY      (oBUSY),
        .oFRAME_DONE(oFRAME_DONE),
        .oERR       (oERR),
        .oPIX_COUNT (oPIX_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Collect output pixels, done pulses and the input FVAL fall on the falling edge.
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (fval_prev && !iFVAL) eof_cyc = cyc;
        fval_prev = iFVAL;
        if (oDATA_VAL) begin
            q_data.push_back(oDATA);
            q_x.push_back(oX);
            q_y.push_back(oY);
        end
        if (oFRAME_DONE) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_x.delete();
        q_y.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_arm();
        @(posedge CLK); #1;
        iARM = 1'b1;
        @(posedge CLK); #1;
        iARM = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // One sensor frame of nlines x 8 pixels: 2 lead-in cycles, 2-cycle line
    // blanking, 4 cycles of FVAL low. Optional arm/reset pulses at a frame cycle.
    task automatic frame(input int nlines, input int arm_at, input int rst_at, input bit arm_on_done);
        int total;
        int p;
        total = 2 + nlines * 10 + 4;
        for (int c = 0; c < total; c++) begin
            @(posedge CLK); #1;
            if (rst_at >= 0 && c == rst_at + 1) begin
                check("rst_busy", 32'(oBUSY), 32'd0);
                check("rst_val", 32'(oDATA_VAL), 32'd0);
                check("rst_count", 32'(oPIX_COUNT), 32'd0);
                check("rst_data", 32'(oDATA), 32'd0);
                check("rst_done", 32'(oFRAME_DONE), 32'd0);
            end
            RST  = (c == rst_at);
            iARM = (c == arm_at) || (arm_on_done && oFRAME_DONE);
            if (c < 2 + nlines * 10) begin
                iFVAL = 1'b1;
                p = c - 2;
                if (p >= 0 && (p % 10) < 8) begin
                    iLVAL = 1'b1;
                    iDATA = {6'(p / 10), 6'(p % 10)};
                end else begin
                    iLVAL = 1'b0;
                end
            end else begin
                iFVAL = 1'b0;
                iLVAL = 1'b0;
            end
        end
        @(posedge CLK); #1;
        RST  = 1'b0;
        iARM = 1'b0;
    endtask

    // Compare collected pixels with the window pattern, then clear the monitor.
    task automatic check_capture(input string tag, input int n, input int n_done);
        int x, y, scol, sline;
        logic [11:0] ed;
        check({tag, "_n"}, 32'(q_data.size()), 32'(n));
        check({tag, "_done"}, 32'(done_cnt), 32'(n_done));
        for (int i = 0; i < n && i < q_data.size(); i++) begin
            x     = i % (WW / STEP);
            y     = i / (WW / STEP);
            scol  = XS + STEP * x;
            sline = YS + STEP * y;
            ed    = {6'(sline), 6'(scol)};
            check({tag, "_data"}, 32'(q_data[i]), 32'(ed));
            check({tag, "_x"}, 32'(q_x[i]), 32'(x));
            check({tag, "_y"}, 32'(q_y[i]), 32'(y));
        end
        clear_mon();
    endtask

    initial begin
        RST   = 1'b1;
        iFVAL = 1'b0;
        iLVAL = 1'b0;
        iDATA = '0;
        iARM  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_busy", 32'(oBUSY), 32'd0);
        check("reset_val", 32'(oDATA_VAL), 32'd0);
        check("reset_done", 32'(oFRAME_DONE), 32'd0);
        check("reset_err", 32'(oERR), 32'd0);
        check("reset_count", 32'(oPIX_COUNT), 32'd0);
        check("reset_data", 32'(oDATA), 32'd0);
        check("reset_xy", 32'({oX, oY}), 32'd0);
        RST = 1'b0;
        idle(3);
        clear_mon();

        // Arm ahead of a full frame.
        pulse_arm();
        check("t1_busy_armed", 32'(oBUSY), 32'd1);
        frame(5, -1, -1, 1'b0);
        idle(3);
        check_capture("t1", FULL_CNT, 1);
        check("t1_err", 32'(oERR), 32'd0);
        check("t1_count", 32'(oPIX_COUNT), 32'(FULL_CNT));
        check("t1_busy_end", 32'(oBUSY), 32'd0);

        // Arm while FVAL is high: that frame is skipped, the next is captured.
        frame(5, 5, -1, 1'b0);
        check_capture("t2_partial", 0, 0);
        check("t2_busy_wait", 32'(oBUSY), 32'd1);
        frame(5, -1, -1, 1'b0);
        idle(3);
        check_capture("t2", FULL_CNT, 1);
        check("t2_count", 32'(oPIX_COUNT), 32'(FULL_CNT));

        // Short frame: FVAL falls after 2 lines.
        pulse_arm();
        frame(2, -1, -1, 1'b0);
        idle(3);
        check("t3_done_lat", 32'(done_cyc - eof_cyc), 32'd1);
        check_capture("t3", SHORT_CNT, 1);
        check("t3_err", 32'(oERR), 32'd1);
        check("t3_count", 32'(oPIX_COUNT), 32'(SHORT_CNT));
        check("t3_busy_end", 32'(oBUSY), 32'd0);
        pulse_arm();
        check("t3_rearm_err", 32'(oERR), 32'd0);
        check("t3_rearm_count", 32'(oPIX_COUNT), 32'd0);
        frame(5, -1, -1, 1'b0);
        idle(3);
        check_capture("t3_rearm", FULL_CNT, 1);
        check("t3_rearm_err_end", 32'(oERR), 32'd0);

        // Arm pulses during CAPTURE and on the done cycle are ignored.
        pulse_arm();
        frame(5, 15, -1, 1'b1);
        idle(3);
        check_capture("t4", FULL_CNT, 1);
        check("t4_busy_end", 32'(oBUSY), 32'd0);
        frame(5, -1, -1, 1'b0);
        idle(3);
        check_capture("t4_noarm", 0, 0);
        check("t4_busy_idle", 32'(oBUSY), 32'd0);

        // Reset for one cycle in the middle of a capture.
        pulse_arm();
        frame(5, -1, 15, 1'b0);
        idle(3);
        check("t5_done", 32'(done_cnt), 32'd0);
        check("t5_busy", 32'(oBUSY), 32'd0);
        check("t5_count", 32'(oPIX_COUNT), 32'd0);
        clear_mon();
        pulse_arm();
        frame(5, -1, -1, 1'b0);
        idle(3);
        check_capture("t5_rearm", FULL_CNT, 1);
        check("t5_rearm_count", 32'(oPIX_COUNT), 32'(FULL_CNT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
